// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the RV64 pipeline.
// Turns EX/MEM load/store controls into one valid/ready request on a 64-bit
// data bus and stalls the front of the pipeline until the response arrives.
// It then lane-extracts and extends load data into a registered MEM/WB bundle.
// Non-memory instructions reach MEM/WB one cycle after capture, with no stall.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently aligning them.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [2:0]  funct3,
    input  logic [63:0] alu_result,
    input  logic [63:0] rs2_data,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic        req_valid,
    output logic        req_we,
    output logic [63:0] req_addr,
    output logic [63:0] req_wdata,
    output logic [7:0]  req_wstrb,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [63:0] rsp_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        misalign_exc
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t      state_reg, state_next;
    logic [63:0] addr_reg;
    logic [63:0] wdata_reg;
    logic [2:0]  funct3_reg;
    logic [4:0]  rd_reg;
    logic        reg_write_reg;
    logic        we_reg;
    logic        wb_valid_reg;
    logic        wb_reg_write_reg;
    logic [4:0]  wb_rd_reg;
    logic [63:0] wb_data_reg;

    logic        is_mem;
    logic        trap_take;
    logic [2:0]  cap_mask;
    logic [63:0] cap_addr;
    logic [2:0]  lat_mask;
    logic [3:0]  lane_last;
    logic [5:0]  lane_shift;
    logic [7:0]  lane_en;
    logic [63:0] lane_data;
    logic [63:0] load_data;

    // Low-address mask of an access: size in bytes minus one (111 acts as doubleword).
    function automatic logic [2:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    assign is_mem   = in_valid && (mem_read || mem_write);
    assign cap_mask = size_mask(funct3[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_reg;
    // Keep the raw address so a trap can report the faulting address.
    assign trap_take    = is_mem && ((alu_result[2:0] & cap_mask) != 3'b000);
    assign cap_addr     = alu_result;
    assign misalign_exc = misalign_reg;
`else
    // Force natural alignment so the lane logic never straddles a doubleword.
    assign trap_take    = 1'b0;
    assign cap_addr     = {alu_result[63:3], alu_result[2:0] & ~cap_mask};
    assign misalign_exc = 1'b0;
`endif

    assign lat_mask   = size_mask(funct3_reg[1:0]);
    assign lane_shift = {addr_reg[2:0], 3'b000};
    assign lane_last  = {1'b0, addr_reg[2:0]} + {1'b0, lat_mask};
    assign lane_data  = rsp_rdata >> lane_shift;

    // Byte strobes: lanes from the access offset up to offset+size-1.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_strobe
            assign lane_en[gi] = (4'(gi) >= {1'b0, addr_reg[2:0]}) && (4'(gi) <= lane_last);
        end
    endgenerate

    // Size and signedness extension of the lane-shifted read data.
    always_comb begin
        load_data = lane_data;
        case (funct3_reg)
            3'b000:  load_data = {{56{lane_data[7]}},  lane_data[7:0]};
            3'b001:  load_data = {{48{lane_data[15]}}, lane_data[15:0]};
            3'b010:  load_data = {{32{lane_data[31]}}, lane_data[31:0]};
            3'b100:  load_data = {56'd0, lane_data[7:0]};
            3'b101:  load_data = {48'd0, lane_data[15:0]};
            3'b110:  load_data = {32'd0, lane_data[31:0]};
            default: load_data = lane_data;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic: EX/MEM is only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (is_mem) state_next = trap_take ? DONE : REQ;
            REQ:  if (req_ready) state_next = WAIT;
            WAIT: if (rsp_valid) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: the request is driven only in REQ; stall is dropped while in reset.
    always_comb begin
        stall     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 64'd0;
        req_wdata = 64'd0;
        req_wstrb = 8'd0;
        case (state_reg)
            IDLE: stall = rst && is_mem;
            REQ: begin
                stall     = 1'b1;
                req_valid = 1'b1;
                req_we    = we_reg;
                req_addr  = {addr_reg[63:3], 3'b000};
                req_wdata = wdata_reg << lane_shift;
                req_wstrb = lane_en;
            end
            WAIT: stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Access latch and MEM/WB bundle; wb_valid is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg         <= 64'd0;
            wdata_reg        <= 64'd0;
            funct3_reg       <= 3'd0;
            rd_reg           <= 5'd0;
            reg_write_reg    <= 1'b0;
            we_reg           <= 1'b0;
            wb_valid_reg     <= 1'b0;
            wb_reg_write_reg <= 1'b0;
            wb_rd_reg        <= 5'd0;
            wb_data_reg      <= 64'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_reg     <= 1'b0;
`endif
        end else begin
            wb_valid_reg <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (is_mem) begin
                        addr_reg      <= cap_addr;
                        wdata_reg     <= rs2_data;
                        funct3_reg    <= funct3;
                        rd_reg        <= rd;
                        reg_write_reg <= reg_write;
                        we_reg        <= mem_write;
                        if (trap_take) begin
                            wb_valid_reg     <= 1'b1;
                            wb_reg_write_reg <= 1'b0;
                            wb_rd_reg        <= rd;
                            wb_data_reg      <= alu_result;
`ifdef MEM_MISALIGN_TRAP_EN
                            misalign_reg     <= 1'b1;
`endif
                        end
                    end else if (in_valid) begin
                        wb_valid_reg     <= 1'b1;
                        wb_reg_write_reg <= reg_write;
                        wb_rd_reg        <= rd;
                        wb_data_reg      <= alu_result;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        wb_valid_reg     <= 1'b1;
                        wb_rd_reg        <= rd_reg;
                        wb_reg_write_reg <= we_reg ? 1'b0 : reg_write_reg;
                        wb_data_reg      <= we_reg ? 64'd0 : load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_valid     = wb_valid_reg;
    assign wb_reg_write = wb_reg_write_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_data      = wb_data_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized checks of mem_access_unit
// against a byte-lane reference model built from plain arithmetic.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_read, mem_write, reg_write;
    logic [2:0]  funct3;
    logic [63:0] alu_result, rs2_data;
    logic [4:0]  rd;
    logic        stall, req_valid, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        req_ready, rsp_valid;
    logic [63:0] rsp_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        misalign_exc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .funct3(funct3),
        .alu_result(alu_result), .rs2_data(rs2_data), .rd(rd), .stall(stall),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_exc(misalign_exc)
    );

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic int unsigned acc_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [63:0] a);
        return (a % 64'(acc_size(f3))) != 64'd0;
    endfunction

    // Address actually used for lane selection.
    function automatic logic [63:0] eff_addr(input logic [2:0] f3, input logic [63:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return a;
`else
        return a - (a % 64'(acc_size(f3)));
`endif
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] ea,
                                             input logic [63:0] rdata);
        int unsigned sz  = acc_size(f3);
        int unsigned off = 32'(ea % 64'd8);
        logic [63:0] m, v;
        m = (sz == 8) ? ~64'd0 : ((64'd1 << (sz * 8)) - 64'd1);
        v = (rdata >> (off * 8)) & m;
        if (f3[2] == 1'b0 && sz < 8 && v[sz*8-1] == 1'b1) v = v | ~m;
        return v;
    endfunction

    function automatic logic [7:0] ref_wstrb(input logic [2:0] f3, input logic [63:0] ea);
        int unsigned off = 32'(ea % 64'd8);
        return 8'(((32'd1 << acc_size(f3)) - 32'd1) << off);
    endfunction

    // One complete memory access with rdly not-ready cycles and sdly response wait cycles.
    task automatic do_mem(input bit is_store, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] data, input int rdly, input int sdly,
                          input logic [4:0] r, input bit rw, input string tag,
                          output logic [63:0] got);
        logic [63:0] ea     = eff_addr(f3, addr);
        logic [63:0] exp_wb = is_store ? 64'd0 : ref_load(f3, ea, data);
        got = 'x;
        @(negedge clk);
        in_valid = 1'b1; mem_read = !is_store; mem_write = is_store; funct3 = f3;
        alu_result = addr; rs2_data = is_store ? data : rnd64(); rd = r; reg_write = rw;
        req_ready = 1'(($urandom) % 2); rsp_valid = 1'(($urandom) % 2); rsp_rdata = rnd64();
        #1;
        checks++;
        if (stall !== 1'b1 || wb_valid !== 1'b0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s capture: stall=%b wb_valid=%b req_valid=%b, need 1 0 0",
                     tag, stall, wb_valid, req_valid);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        if (is_misaligned(f3, addr)) begin
            @(negedge clk);
            in_valid = 1'b0; req_ready = 1'b1; rsp_valid = 1'b1;
            #1;
            checks++;
            if (req_valid !== 1'b0 || misalign_exc !== 1'b1 || wb_valid !== 1'b1 ||
                wb_reg_write !== 1'b0 || wb_data !== addr || stall !== 1'b0) begin
                errors++;
                $display("FAIL %s trap: req_valid=%b exc=%b wb_valid=%b wb_rw=%b wb_data=%h stall=%b, need 0 1 1 0 %h 0",
                         tag, req_valid, misalign_exc, wb_valid, wb_reg_write, wb_data, stall, addr);
            end
            got = wb_data;
            $display("trap %s f3=%0d addr=%h wb_data=%h", tag, f3, addr, wb_data);
            return;
        end
`endif
        for (int i = 0; i <= rdly; i++) begin
            @(negedge clk);
            req_ready = (i == rdly);
            rsp_valid = (i < rdly) ? 1'(($urandom) % 2) : 1'b0;
            rsp_rdata = rnd64();
            #1;
            checks++;
            if (req_valid !== 1'b1 || req_we !== is_store || stall !== 1'b1 ||
                req_addr !== (ea & ~64'd7)) begin
                errors++;
                $display("FAIL %s req[%0d]: valid=%b we=%b stall=%b addr=%h, need 1 %b 1 %h",
                         tag, i, req_valid, req_we, stall, req_addr, is_store, ea & ~64'd7);
            end
            if (is_store) begin
                checks++;
                if (req_wdata !== (data << ((ea % 64'd8) * 8)) || req_wstrb !== ref_wstrb(f3, ea)) begin
                    errors++;
                    $display("FAIL %s store lanes: wdata=%h wstrb=%h, need %h %h", tag, req_wdata,
                             req_wstrb, data << ((ea % 64'd8) * 8), ref_wstrb(f3, ea));
                end
            end
        end
        for (int j = 0; j <= sdly; j++) begin
            @(negedge clk);
            req_ready = 1'(($urandom) % 2);
            rsp_valid = (j == sdly);
            rsp_rdata = (j == sdly && !is_store) ? data : rnd64();
            #1;
            checks++;
            if (req_valid !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s wait[%0d]: req_valid=%b stall=%b wb_valid=%b, need 0 1 0",
                         tag, j, req_valid, stall, wb_valid);
            end
        end
        @(negedge clk);
        // A non-memory op offered during DONE must be ignored.
        in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; alu_result = rnd64();
        req_ready = 1'(($urandom) % 2); rsp_valid = 1'(($urandom) % 2);
        #1;
        checks++;
        if (wb_valid !== 1'b1 || stall !== 1'b0 || wb_rd !== r || misalign_exc !== 1'b0 ||
            wb_reg_write !== (is_store ? 1'b0 : rw) || wb_data !== exp_wb) begin
            errors++;
            $display("FAIL %s done: wb_valid=%b stall=%b rd=%0d exc=%b rw=%b data=%h, need 1 0 %0d 0 %b %h",
                     tag, wb_valid, stall, wb_rd, misalign_exc, wb_reg_write, wb_data, r,
                     is_store ? 1'b0 : rw, exp_wb);
        end
        got = wb_data;
        $display("mem %s st=%0d f3=%0d addr=%h rdly=%0d sdly=%0d wb_data=%h", tag, is_store, f3,
                 addr, rdly, sdly, wb_data);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: wb_valid=%b stall=%b, need 0 0", tag, wb_valid, stall);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
        funct3 = 3'b011; alu_result = 64'h40; rs2_data = 64'd0; rd = 5'd1;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = rnd64();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({stall, req_valid, req_we, wb_valid, wb_reg_write, misalign_exc} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: stall/req_valid/req_we/wb_valid/wb_rw/exc=%b, need 000000",
                     {stall, req_valid, req_we, wb_valid, wb_reg_write, misalign_exc});
        end
        checks++;
        if (req_addr !== 64'd0 || req_wdata !== 64'd0 || req_wstrb !== 8'd0 ||
            wb_rd !== 5'd0 || wb_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h wb_rd=%0d wb_data=%h, need zeros",
                     req_addr, req_wdata, req_wstrb, wb_rd, wb_data);
        end
        @(negedge clk);
        in_valid = 1'b0; mem_read = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        rst = 1'b1;
        $display("reset checked");
        idle_check("post_reset");
    endtask

    task automatic test_passthrough;
        logic [63:0] held_data;
        logic [4:0]  held_rd;
        logic        held_rw, prev_v, v;
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; alu_result = 64'h2A; rd = 5'd5;
        reg_write = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL add_stall: stall=%b, need 0", stall);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 64'h2A || wb_rd !== 5'd5 || wb_reg_write !== 1'b1 ||
            stall !== 1'b0) begin
            errors++;
            $display("FAIL add_wb: valid=%b data=%h rd=%0d rw=%b stall=%b, need 1 2a 5 1 0",
                     wb_valid, wb_data, wb_rd, wb_reg_write, stall);
        end
        $display("add passthrough wb_data=%h wb_rd=%0d", wb_data, wb_rd);
        held_data = 64'h2A; held_rd = 5'd5; held_rw = 1'b1; prev_v = 1'b0;
        for (int i = 0; i <= 24; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (wb_valid !== prev_v || wb_data !== held_data || wb_rd !== held_rd ||
                wb_reg_write !== held_rw) begin
                errors++;
                $display("FAIL pass[%0d]: valid=%b data=%h rd=%0d rw=%b, need %b %h %0d %b", i,
                         wb_valid, wb_data, wb_rd, wb_reg_write, prev_v, held_data, held_rd, held_rw);
            end
            v = (i < 24) ? 1'(($urandom) % 2) : 1'b0;
            in_valid = v; alu_result = rnd64(); rd = 5'($urandom); reg_write = 1'($urandom);
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL pass_stall[%0d]: stall=%b, need 0", i, stall);
            end
            if (v) begin
                held_data = alu_result; held_rd = rd; held_rw = reg_write;
            end
            prev_v = v;
        end
        $display("random passthrough done");
    endtask

    task automatic test_loads;
        logic [63:0] got;
        do_mem(1'b0, 3'b000, 64'h103, 64'h0000_0000_8000_0000, 0, 0, 5'd7, 1'b1, "lb", got);
        checks++;
        if (got !== 64'hFFFF_FFFF_FFFF_FF80) begin
            errors++;
            $display("FAIL lb_value: got %h, need ffffffffffffff80", got);
        end
        do_mem(1'b0, 3'b100, 64'h103, 64'h0000_0000_8000_0000, 0, 0, 5'd8, 1'b1, "lbu", got);
        checks++;
        if (got !== 64'h80) begin
            errors++;
            $display("FAIL lbu_value: got %h, need 80", got);
        end
    endtask

    task automatic test_store;
        logic [63:0] got;
        do_mem(1'b1, 3'b001, 64'h206, 64'hBEEF, 0, 0, 5'd9, 1'b1, "sh", got);
        checks++;
        if (got !== 64'd0 || wb_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL sh_wb: data=%h rw=%b, need 0 0", got, wb_reg_write);
        end
    endtask

    task automatic test_ready_hold;
        logic [63:0] got;
        do_mem(1'b0, 3'b011, 64'h1000, 64'h0123_4567_89AB_CDEF, 5, 0, 5'd10, 1'b1, "ld_hold", got);
        checks++;
        if (got !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL ld_hold_value: got %h, need 0123456789abcdef", got);
        end
    endtask

    task automatic test_misaligned;
        logic [63:0] got;
        do_mem(1'b0, 3'b010, 64'h102, 64'h1122_3344_5566_7788, 0, 0, 5'd11, 1'b1, "lw_mis", got);
        checks++;
`ifdef MEM_MISALIGN_TRAP_EN
        if (got !== 64'h102) begin
            errors++;
            $display("FAIL lw_mis_value: got %h, need 102", got);
        end
`else
        if (got !== 64'h5566_7788) begin
            errors++;
            $display("FAIL lw_mis_value: got %h, need 55667788", got);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [63:0] got;
        bit          st;
        logic [2:0]  f3;
        for (int n = 0; n < 40; n++) begin
            st = 1'(($urandom) % 2);
            f3 = st ? 3'($urandom % 4) : 3'($urandom % 8);
            do_mem(st, f3, rnd64(), rnd64(), int'($urandom % 3), int'($urandom % 3),
                   5'($urandom), 1'($urandom), "rand", got);
        end
        idle_check("after_rand");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011;
        alu_result = 64'h300; rd = 5'd12; reg_write = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0;
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait: stall=%b req_valid=%b, need 1 0", stall, req_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || req_valid !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort: stall=%b req_valid=%b wb_valid=%b, need 0 0 0",
                     stall, req_valid, wb_valid);
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; mem_read = 1'b0; rsp_valid = 1'b1; rsp_rdata = rnd64();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rsp_valid = 1'b0;
            #1;
            checks++;
            if (wb_valid !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL rst_late_rsp[%0d]: wb_valid=%b stall=%b, need 0 0", k, wb_valid, stall);
            end
        end
        $display("reset during WAIT checked");
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_loads();
        test_store();
        test_ready_hold();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
